// File: rtl/addrunit_q_pkg.sv
// rtl/addrunit_q_pkg.sv - shared widths and memory opcode encodings for addrunit_q
package addrunit_q_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int ROB_W_DEF  = 4;
  localparam int OP_W_DEF   = 6;
  localparam int DEPTH_DEF  = 4;

  // Loads and stores each occupy one contiguous range so decode is a pair of compares
  typedef enum logic [OP_W_DEF-1:0] {
    OP_LB  = 6'd10,
    OP_LH  = 6'd11,
    OP_LW  = 6'd12,
    OP_LBU = 6'd13,
    OP_LHU = 6'd14,
    OP_SB  = 6'd15,
    OP_SH  = 6'd16,
    OP_SW  = 6'd17
  } mem_op_e;

endpackage

// File: rtl/addrunit_fifo.sv
// rtl/addrunit_fifo.sv - circular queue with occupancy count, global enable and flush
module addrunit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [PW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= wdata;
          wr_ptr      <= wr_ptr + PW'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + PW'(1);
        case ({do_push, do_pop})
          2'b10:   count <= count + (PW+1)'(1);
          2'b01:   count <= count - (PW+1)'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/addrunit_q.sv
// rtl/addrunit_q.sv - address unit: queues vj+a and routes loads to the load buffer, stores to the ROB
// Optional ADDRUNIT_MISALIGN_EN reroutes misaligned accesses to the ROB with a misalign flag.
module addrunit_q
  import addrunit_q_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              rs_addrunit_valid_in,
  output logic              rs_addrunit_ready_out,
  input  logic [ADDR_W-1:0] rs_addrunit_a_in,
  input  logic [ADDR_W-1:0] rs_addrunit_vj_in,
  input  logic [ROB_W-1:0]  rs_addrunit_dest_in,
  input  logic [OP_W-1:0]   rs_addrunit_opcode_in,
  output logic              addrunit_lbuffer_en_out,
  input  logic              lbuffer_addrunit_ready_in,
  output logic [ADDR_W-1:0] addrunit_lbuffer_a_out,
  output logic [ROB_W-1:0]  addrunit_lbuffer_dest_out,
  output logic [OP_W-1:0]   addrunit_lbuffer_opcode_out,
  output logic              addrunit_rob_en_out,
  output logic [ROB_W-1:0]  addrunit_rob_h_out,
  output logic [ADDR_W-1:0] addrunit_rob_address_out,
`ifdef ADDRUNIT_MISALIGN_EN
  output logic              addrunit_rob_misalign_out,
`endif
  input  logic              rob_addrunit_rst_in
);

  localparam int PAY_W = ADDR_W + ROB_W + OP_W;

  logic [PAY_W-1:0]  enq_data;
  logic [PAY_W-1:0]  head;
  logic [ADDR_W-1:0] head_addr;
  logic [ROB_W-1:0]  head_dest;
  logic [OP_W-1:0]   head_op;
  logic              full;
  logic              empty;
  logic              pop;
  logic              head_live;
  logic              is_load;
  logic              is_store;
  logic              misaligned;
  logic              to_lb;
  logic              to_rob;

  assign enq_data = {rs_addrunit_vj_in + rs_addrunit_a_in, rs_addrunit_dest_in, rs_addrunit_opcode_in};
  assign {head_addr, head_dest, head_op} = head;

  assign is_load  = (head_op >= OP_W'(OP_LB)) && (head_op <= OP_W'(OP_LHU));
  assign is_store = (head_op >= OP_W'(OP_SB)) && (head_op <= OP_W'(OP_SW));

`ifdef ADDRUNIT_MISALIGN_EN
  always_comb begin
    misaligned = 1'b0;
    if (head_op == OP_W'(OP_LH) || head_op == OP_W'(OP_LHU) || head_op == OP_W'(OP_SH))
      misaligned = head_addr[0];
    else if (head_op == OP_W'(OP_LW) || head_op == OP_W'(OP_SW))
      misaligned = (head_addr[1:0] != 2'b00);
  end
`else
  assign misaligned = 1'b0;
`endif

  assign to_lb     = is_load && !misaligned;
  assign to_rob    = is_store || (is_load && misaligned);
  assign head_live = rdy_in && !empty;
  // Only a load bound for the load buffer waits; ROB strobes and unknown ops leave in one cycle
  assign pop       = head_live && (!to_lb || lbuffer_addrunit_ready_in);

  addrunit_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(PAY_W)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .en    (rdy_in),
    .flush (rob_addrunit_rst_in),
    .push  (rs_addrunit_valid_in),
    .pop   (pop),
    .wdata (enq_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign rs_addrunit_ready_out       = !full;
  assign addrunit_lbuffer_en_out     = head_live && to_lb;
  assign addrunit_lbuffer_a_out      = (!empty && to_lb) ? head_addr : '0;
  assign addrunit_lbuffer_dest_out   = (!empty && to_lb) ? head_dest : '0;
  assign addrunit_lbuffer_opcode_out = (!empty && to_lb) ? head_op : '0;
  assign addrunit_rob_en_out         = head_live && to_rob;
  assign addrunit_rob_h_out          = (!empty && to_rob) ? head_dest : '0;
  assign addrunit_rob_address_out    = (!empty && to_rob) ? head_addr : '0;
`ifdef ADDRUNIT_MISALIGN_EN
  assign addrunit_rob_misalign_out   = addrunit_rob_en_out && misaligned;
`endif

endmodule

// File: tb/tb_addrunit_q.sv
// tb/tb_addrunit_q.sv - directed self-checking bench for addrunit_q
module tb_addrunit_q;
  import addrunit_q_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        valid = 1'b0;
  logic        ready;
  logic [31:0] a_in = '0;
  logic [31:0] vj_in = '0;
  logic [3:0]  dest_in = '0;
  logic [5:0]  op_in = '0;
  logic        lb_en;
  logic        lb_ready = 1'b0;
  logic [31:0] lb_a;
  logic [3:0]  lb_dest;
  logic [5:0]  lb_op;
  logic        rob_en;
  logic [3:0]  rob_h;
  logic [31:0] rob_addr;
  logic        flush = 1'b0;
`ifdef ADDRUNIT_MISALIGN_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addrunit_q dut (
    .clk_in                      (clk),
    .rst_in                      (rst),
    .rdy_in                      (rdy),
    .rs_addrunit_valid_in        (valid),
    .rs_addrunit_ready_out       (ready),
    .rs_addrunit_a_in            (a_in),
    .rs_addrunit_vj_in           (vj_in),
    .rs_addrunit_dest_in         (dest_in),
    .rs_addrunit_opcode_in       (op_in),
    .addrunit_lbuffer_en_out     (lb_en),
    .lbuffer_addrunit_ready_in   (lb_ready),
    .addrunit_lbuffer_a_out      (lb_a),
    .addrunit_lbuffer_dest_out   (lb_dest),
    .addrunit_lbuffer_opcode_out (lb_op),
    .addrunit_rob_en_out         (rob_en),
    .addrunit_rob_h_out          (rob_h),
    .addrunit_rob_address_out    (rob_addr),
`ifdef ADDRUNIT_MISALIGN_EN
    .addrunit_rob_misalign_out   (misalign),
`endif
    .rob_addrunit_rst_in         (flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic v, input logic [31:0] vj, input logic [31:0] a,
                        input logic [3:0] d, input logic [5:0] op);
    valid = v; vj_in = vj; a_in = a; dest_in = d; op_in = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    checks++; if (lb_en !== 1'b0) begin errors++; $display("FAIL reset_lb_en: got %0b want 0", lb_en); end
    checks++; if (rob_en !== 1'b0) begin errors++; $display("FAIL reset_rob_en: got %0b want 0", rob_en); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", ready); end
    checks++; if (lb_a !== 32'h0) begin errors++; $display("FAIL reset_lb_a: got %h want 0", lb_a); end
    checks++; if (rob_addr !== 32'h0) begin errors++; $display("FAIL reset_rob_addr: got %h want 0", rob_addr); end
  endtask

  task automatic test_load();
    lb_ready = 1'b0;
    set_op(1'b1, 32'h1000, 32'h24, 4'd3, OP_LW);
    #1;
    checks++; if (lb_en !== 1'b0) begin errors++; $display("FAIL load_no_bypass: got %0b want 0", lb_en); end
    tick();
    valid = 1'b0;
    checks++; if (lb_en !== 1'b1) begin errors++; $display("FAIL load_en: got %0b want 1", lb_en); end
    checks++; if (lb_a !== 32'h1024) begin errors++; $display("FAIL load_addr: got %h want 00001024", lb_a); end
    checks++; if (lb_dest !== 4'd3) begin errors++; $display("FAIL load_dest: got %0d want 3", lb_dest); end
    checks++; if (lb_op !== 6'(OP_LW)) begin errors++; $display("FAIL load_op: got %0d want %0d", lb_op, OP_LW); end
    checks++; if (rob_en !== 1'b0) begin errors++; $display("FAIL load_rob_en: got %0b want 0", rob_en); end
    tick();
    checks++; if (lb_en !== 1'b1) begin errors++; $display("FAIL load_hold: got %0b want 1", lb_en); end
    lb_ready = 1'b1;
    tick();
    checks++; if (lb_en !== 1'b0) begin errors++; $display("FAIL load_drained: got %0b want 0", lb_en); end
  endtask

  task automatic test_store_wrap();
    set_op(1'b1, 32'hFFFF_FFFC, 32'h8, 4'd5, OP_SW);
    tick();
    valid = 1'b0;
    checks++; if (rob_en !== 1'b1) begin errors++; $display("FAIL store_en: got %0b want 1", rob_en); end
    checks++; if (rob_addr !== 32'h4) begin errors++; $display("FAIL store_addr: got %h want 00000004", rob_addr); end
    checks++; if (rob_h !== 4'd5) begin errors++; $display("FAIL store_h: got %0d want 5", rob_h); end
    checks++; if (lb_en !== 1'b0) begin errors++; $display("FAIL store_lb_en: got %0b want 0", lb_en); end
    tick();
    checks++; if (rob_en !== 1'b0) begin errors++; $display("FAIL store_single_strobe: got %0b want 0", rob_en); end
  endtask

  task automatic test_other_op();
    set_op(1'b1, 32'h50, 32'h0, 4'd6, 6'd1);
    tick();
    checks++; if ({lb_en, rob_en} !== 2'b00) begin errors++; $display("FAIL other_silent: got %b want 00", {lb_en, rob_en}); end
    set_op(1'b1, 32'h60, 32'h0, 4'd4, OP_LB);
    tick();
    valid = 1'b0;
    checks++; if (lb_dest !== 4'd4 || lb_en !== 1'b1) begin errors++; $display("FAIL other_dequeued: got en %0b dest %0d want en 1 dest 4", lb_en, lb_dest); end
    tick();
  endtask

  task automatic test_full();
    lb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_op(1'b1, 32'h100, 32'(i * 4), 4'(i), OP_LW);
      tick();
    end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", ready); end
    set_op(1'b1, 32'h900, 32'h0, 4'd9, OP_LW);
    tick();
    valid = 1'b0;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL full_still: got %0b want 0", ready); end
    lb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lb_en !== 1'b1 || lb_dest !== 4'(i) || lb_a !== 32'h100 + 32'(i * 4)) begin
        errors++; $display("FAIL drain_%0d: got en %0b dest %0d addr %h want en 1 dest %0d addr %h", i, lb_en, lb_dest, lb_a, i, 32'h100 + 32'(i * 4));
      end
      tick();
    end
    checks++; if (lb_en !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL full_fifth_rejected: got en %0b ready %0b want 0 1", lb_en, ready); end
  endtask

  task automatic test_flush();
    lb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_op(1'b1, 32'h200, 32'(i), 4'(i), OP_LW);
      tick();
    end
    set_op(1'b1, 32'h700, 32'h0, 4'd7, OP_LW);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    valid = 1'b0;
    checks++; if ({lb_en, rob_en, ready} !== 3'b001) begin errors++; $display("FAIL flush_state: got %b want 001", {lb_en, rob_en, ready}); end
    tick();
    checks++; if (lb_en !== 1'b0) begin errors++; $display("FAIL flush_enq_ignored: got %0b want 0", lb_en); end
    lb_ready = 1'b1;
  endtask

  task automatic test_rdy_stall();
    lb_ready = 1'b1;
    set_op(1'b1, 32'h300, 32'h0, 4'd1, OP_LW);
    tick();
    rdy = 1'b0;
    set_op(1'b1, 32'h340, 32'h0, 4'd2, OP_LW);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({lb_en, rob_en} !== 2'b00) begin errors++; $display("FAIL stall_%0d: got %b want 00", i, {lb_en, rob_en}); end
    end
    rdy = 1'b1;
    valid = 1'b0;
    #1;
    checks++; if (lb_en !== 1'b1 || lb_dest !== 4'd1) begin errors++; $display("FAIL stall_resume: got en %0b dest %0d want 1 1", lb_en, lb_dest); end
    tick();
    checks++; if (lb_en !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL stall_no_enq: got en %0b ready %0b want 0 1", lb_en, ready); end
    set_op(1'b1, 32'h340, 32'h0, 4'd2, OP_LW);
    tick();
    valid = 1'b0;
    checks++; if (lb_a !== 32'h340 || lb_dest !== 4'd2) begin errors++; $display("FAIL stall_stream: got addr %h dest %0d want 00000340 2", lb_a, lb_dest); end
    tick();
  endtask

  task automatic test_back_to_back();
    lb_ready = 1'b1;
    set_op(1'b1, 32'h200, 32'h10, 4'd1, OP_LHU);
    tick();
    checks++; if (lb_en !== 1'b1 || lb_a !== 32'h210) begin errors++; $display("FAIL b2b_load: got en %0b addr %h want 1 00000210", lb_en, lb_a); end
    set_op(1'b1, 32'h300, 32'h4, 4'd2, OP_SB);
    tick();
    checks++; if (rob_en !== 1'b1 || rob_addr !== 32'h304 || rob_h !== 4'd2 || lb_en !== 1'b0) begin
      errors++; $display("FAIL b2b_store: got en %0b addr %h h %0d lb %0b want 1 00000304 2 0", rob_en, rob_addr, rob_h, lb_en);
    end
    set_op(1'b1, 32'h400, 32'h0, 4'd3, OP_LW);
    tick();
    valid = 1'b0;
    checks++; if (lb_en !== 1'b1 || lb_dest !== 4'd3 || rob_en !== 1'b0) begin errors++; $display("FAIL b2b_load2: got en %0b dest %0d rob %0b want 1 3 0", lb_en, lb_dest, rob_en); end
    tick();
    checks++; if (lb_en !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL b2b_empty: got en %0b ready %0b want 0 1", lb_en, ready); end
  endtask

  task automatic test_reset_override();
    lb_ready = 1'b0;
    set_op(1'b1, 32'h500, 32'h0, 4'd8, OP_LW);
    tick();
    valid = 1'b1;
    rdy = 1'b0;
    flush = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    flush = 1'b0;
    rdy = 1'b1;
    valid = 1'b0;
    #1;
    checks++; if ({lb_en, ready} !== 2'b01 || lb_a !== 32'h0) begin errors++; $display("FAIL reset_override: got en %0b ready %0b addr %h want 0 1 0", lb_en, ready, lb_a); end
    lb_ready = 1'b1;
  endtask

`ifdef ADDRUNIT_MISALIGN_EN
  task automatic test_misalign();
    set_op(1'b1, 32'h1000, 32'h1, 4'd6, OP_LH);
    tick();
    valid = 1'b0;
    checks++; if (rob_en !== 1'b1 || misalign !== 1'b1 || lb_en !== 1'b0) begin
      errors++; $display("FAIL misalign_lh: got rob %0b mis %0b lb %0b want 1 1 0", rob_en, misalign, lb_en);
    end
    checks++; if (rob_addr !== 32'h1001 || rob_h !== 4'd6) begin errors++; $display("FAIL misalign_addr: got %h h %0d want 00001001 6", rob_addr, rob_h); end
    tick();
    checks++; if (rob_en !== 1'b0) begin errors++; $display("FAIL misalign_strobe: got %0b want 0", rob_en); end
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_store_wrap();
    test_other_op();
    test_full();
    test_flush();
    test_rdy_stall();
    test_back_to_back();
    test_reset_override();
`ifdef ADDRUNIT_MISALIGN_EN
    test_misalign();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
